// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the x32 next-PC sequencer: PC-mux selector values,
// request kinds, exception causes and FSM state codes.
package cpu_ctrl_pkg;

    localparam logic [2:0] SEL_PC4    = 3'd0;
    localparam logic [2:0] SEL_BRANCH = 3'd1;
    localparam logic [2:0] SEL_JUMP   = 3'd2;
    localparam logic [2:0] SEL_REG    = 3'd3;
    localparam logic [2:0] SEL_EPC    = 3'd4;
    localparam logic [2:0] SEL_EXCVEC = 3'd5;

    typedef enum logic [2:0] {
        REQ_SEQ  = 3'd0,
        REQ_BEQ  = 3'd1,
        REQ_BNE  = 3'd2,
        REQ_BGT  = 3'd3,
        REQ_JUMP = 3'd4,
        REQ_JR   = 3'd5,
        REQ_RTE  = 3'd6,
        REQ_RSVD = 3'd7
    } req_kind_t;

    localparam logic [1:0] CAUSE_NONE = 2'd0;
    localparam logic [1:0] CAUSE_OPC  = 2'd1;
    localparam logic [1:0] CAUSE_OVF  = 2'd2;
    localparam logic [1:0] CAUSE_DIV0 = 2'd3;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_FETCH    = 3'd1;
    localparam logic [2:0] ST_RESOLVE  = 3'd2;
    localparam logic [2:0] ST_EXC_SAVE = 3'd3;
    localparam logic [2:0] ST_EXC_WAIT = 3'd4;
    localparam logic [2:0] ST_EXC_LOAD = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE     = ST_IDLE,
        S_FETCH    = ST_FETCH,
        S_RESOLVE  = ST_RESOLVE,
        S_EXC_SAVE = ST_EXC_SAVE,
        S_EXC_WAIT = ST_EXC_WAIT,
        S_EXC_LOAD = ST_EXC_LOAD
    } state_t;

    // Invalid opcode outranks overflow, which outranks divide-by-zero.
    function automatic logic [1:0] exc_prio(input logic opc, input logic ovf, input logic div0);
        if (opc)       return CAUSE_OPC;
        else if (ovf)  return CAUSE_OVF;
        else if (div0) return CAUSE_DIV0;
        else           return CAUSE_NONE;
    endfunction

endpackage

// File: rtl/lat_counter.sv
// Memory-latency counter: counts while enabled, clears on demand and flags
// the last wait cycle (count == MEM_LAT-1).
module lat_counter
#(
    parameter int CNT_W   = 4,
    parameter int MEM_LAT = 3
)
(
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(MEM_LAT - 1);

    logic [CNT_W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n || clr)
            cnt <= '0;
        else if (en)
            cnt <= cnt + 1'b1;
    end

    assign tc = (cnt == TC_VAL);

endmodule

// File: rtl/pc_update_ctrl.sv
// Next-PC sequencer: commits PC+4 at fetch, resolves branch/jump/return
// requests and runs the EPC-save / vector-load exception sequence.
module pc_update_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int MEM_LAT = 3,
    parameter int CNT_W   = 4
)
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       fetch,
    input  logic       req_valid,
    input  logic [2:0] req_kind,
    input  logic       alu_zero,
    input  logic       alu_gt,
    input  logic       exc_ovf,
    input  logic       exc_opc,
    input  logic       exc_div0,
    output logic [2:0] pc_src_sel,
    output logic       pc_write,
    output logic       epc_write,
    output logic       exc_rd,
    output logic [1:0] exc_cause,
    output logic       busy,
    output logic       done
);

    state_t     state, state_nxt;
    req_kind_t  kind_q;
    logic [1:0] cause_q, cause_nxt;
    logic       kind_ld;
    logic       exc_any;
    logic       tc;
    logic       pw, ew, rd, dn;

    assign exc_any = exc_opc | exc_ovf | exc_div0;

    lat_counter #(.CNT_W(CNT_W), .MEM_LAT(MEM_LAT)) u_lat (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state != S_EXC_WAIT),
        .en    (state == S_EXC_WAIT),
        .tc    (tc)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            kind_q  <= REQ_SEQ;
            cause_q <= CAUSE_NONE;
        end else begin
            state <= state_nxt;
            if (kind_ld)
                kind_q <= req_kind_t'(req_kind);
            if (state_nxt == S_EXC_SAVE)
                cause_q <= cause_nxt;
        end
    end

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        state_nxt  = state;
        kind_ld    = 1'b0;
        cause_nxt  = exc_prio(exc_opc, exc_ovf, exc_div0);
        pc_src_sel = SEL_PC4;
        pw         = 1'b0;
        ew         = 1'b0;
        rd         = 1'b0;
        dn         = 1'b0;
        case (state)
            S_IDLE: begin
                if (exc_any)
                    state_nxt = S_EXC_SAVE;
                else if (fetch)
                    state_nxt = S_FETCH;
                else if (req_valid) begin
                    state_nxt = S_RESOLVE;
                    kind_ld   = 1'b1;
                end
            end
            S_FETCH: begin
                pw        = 1'b1;
                state_nxt = S_IDLE;
            end
            S_RESOLVE: begin
                if (kind_q == REQ_RSVD || exc_any) begin
                    state_nxt = S_EXC_SAVE;
                    if (kind_q == REQ_RSVD)
                        cause_nxt = CAUSE_OPC;
                end else begin
                    state_nxt = S_IDLE;
                    dn        = 1'b1;
                    case (kind_q)
                        REQ_BEQ:  begin pc_src_sel = SEL_BRANCH; pw = alu_zero;  end
                        REQ_BNE:  begin pc_src_sel = SEL_BRANCH; pw = ~alu_zero; end
                        REQ_BGT:  begin pc_src_sel = SEL_BRANCH; pw = alu_gt;    end
                        REQ_JUMP: begin pc_src_sel = SEL_JUMP;   pw = 1'b1;      end
                        REQ_JR:   begin pc_src_sel = SEL_REG;    pw = 1'b1;      end
                        REQ_RTE:  begin pc_src_sel = SEL_EPC;    pw = 1'b1;      end
                        default:  ;
                    endcase
                end
            end
            S_EXC_SAVE: begin
                ew        = 1'b1;
                state_nxt = S_EXC_WAIT;
            end
            S_EXC_WAIT: begin
                rd = 1'b1;
                if (tc)
                    state_nxt = S_EXC_LOAD;
            end
            S_EXC_LOAD: begin
                pc_src_sel = SEL_EXCVEC;
                pw         = 1'b1;
                rd         = 1'b1;
                dn         = 1'b1;
                state_nxt  = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // A reset cycle must never commit a PC/EPC write or signal completion.
    assign pc_write  = pw & rst_n;
    assign epc_write = ew & rst_n;
    assign done      = dn & rst_n;
    assign exc_rd    = rd;
    assign exc_cause = cause_q;
    assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_pc_update_ctrl.sv
// Directed bench for pc_update_ctrl: each step pushes the expected outputs
// for the following edge to a scoreboard queue, popped and compared after it.
module tb_pc_update_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       fetch, req_valid, alu_zero, alu_gt, exc_ovf, exc_opc, exc_div0;
    logic [2:0] req_kind;
    logic [2:0] pc_src_sel;
    logic       pc_write, epc_write, exc_rd, busy, done;
    logic [1:0] exc_cause;

    typedef struct packed {
        logic [2:0] sel;
        logic       pw;
        logic       ew;
        logic       rd;
        logic [1:0] cause;
        logic       busy;
        logic       done;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    pc_update_ctrl #(.MEM_LAT(3), .CNT_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fetch      (fetch),
        .req_valid  (req_valid),
        .req_kind   (req_kind),
        .alu_zero   (alu_zero),
        .alu_gt     (alu_gt),
        .exc_ovf    (exc_ovf),
        .exc_opc    (exc_opc),
        .exc_div0   (exc_div0),
        .pc_src_sel (pc_src_sel),
        .pc_write   (pc_write),
        .epc_write  (epc_write),
        .exc_rd     (exc_rd),
        .exc_cause  (exc_cause),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic expect_o(input logic [2:0] sel, input logic pw, input logic ew, input logic rd,
                            input logic [1:0] cause, input logic bsy, input logic dn);
        exp_t e;
        e = '{sel: sel, pw: pw, ew: ew, rd: rd, cause: cause, busy: bsy, done: dn};
        sb.push_back(e);
    endtask

    // Drive one cycle of inputs, then compare against the oldest expectation.
    task automatic step(input string tag, input logic r, input logic f, input logic rv,
                        input logic [2:0] k, input logic z, input logic g,
                        input logic ov, input logic op, input logic d0);
        exp_t e;
        @(negedge clk);
        rst_n = r; fetch = f; req_valid = rv; req_kind = k;
        alu_zero = z; alu_gt = g; exc_ovf = ov; exc_opc = op; exc_div0 = d0;
        @(posedge clk);
        #1;
        checks++;
        assert (sb.size() > 0) else begin
            errors++;
            $error("FAIL %s_queue: observed empty expected entry", tag);
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_sel"},   pc_src_sel,        e.sel);
            chk({tag, "_pw"},    {2'b0, pc_write},  {2'b0, e.pw});
            chk({tag, "_ew"},    {2'b0, epc_write}, {2'b0, e.ew});
            chk({tag, "_rd"},    {2'b0, exc_rd},    {2'b0, e.rd});
            chk({tag, "_cause"}, {1'b0, exc_cause}, {1'b0, e.cause});
            chk({tag, "_busy"},  {2'b0, busy},      {2'b0, e.busy});
            chk({tag, "_done"},  {2'b0, done},      {2'b0, e.done});
        end
    endtask

    task automatic idle(input string tag, input logic [1:0] cause);
        expect_o(3'd0, 0, 0, 0, cause, 0, 0);
        step(tag, 1, 0, 0, 3'd0, 0, 0, 0, 0, 0);
    endtask

    // Resolve one request kind, then return to IDLE.
    task automatic req(input string tag, input logic [2:0] k, input logic z, input logic g,
                       input logic [2:0] sel, input logic pw);
        expect_o(sel, pw, 0, 0, 2'd0, 1, 1);
        step(tag, 1, 0, 1, k, z, g, 0, 0, 0);
        idle({tag, "_idle"}, 2'd0);
    endtask

    // EXC_WAIT x3 then EXC_LOAD; held requests during the wait are ignored.
    task automatic exc_tail(input string tag, input logic [1:0] cause);
        for (int i = 0; i < 3; i++) begin
            expect_o(3'd0, 0, 0, 1, cause, 1, 0);
            step({tag, "_wait"}, 1, 1, 0, 3'd0, 0, 0, 0, 0, 1);
        end
        expect_o(3'd5, 1, 0, 1, cause, 1, 1);
        step({tag, "_load"}, 1, 0, 0, 3'd0, 0, 0, 0, 0, 1);
        idle({tag, "_idle"}, cause);
    endtask

    initial begin
        rst_n = 1'b0; fetch = 1'b0; req_valid = 1'b0; req_kind = 3'd0;
        alu_zero = 1'b0; alu_gt = 1'b0; exc_ovf = 1'b0; exc_opc = 1'b0; exc_div0 = 1'b0;

        expect_o(3'd0, 0, 0, 0, 2'd0, 0, 0);
        step("reset", 0, 0, 0, 3'd0, 0, 0, 0, 0, 0);

        expect_o(3'd0, 1, 0, 0, 2'd0, 1, 0);
        step("fetch", 1, 1, 0, 3'd0, 0, 0, 0, 0, 0);
        idle("fetch_idle", 2'd0);

        req("beq_t",  3'd1, 1, 0, 3'd1, 1);
        req("beq_nt", 3'd1, 0, 0, 3'd1, 0);
        req("bne_t",  3'd2, 0, 0, 3'd1, 1);
        req("bgt_t",  3'd3, 0, 1, 3'd1, 1);
        req("bgt_nt", 3'd3, 1, 0, 3'd1, 0);
        req("jump",   3'd4, 0, 0, 3'd2, 1);
        req("jr",     3'd5, 0, 0, 3'd3, 1);
        req("rte",    3'd6, 0, 0, 3'd4, 1);
        req("seq",    3'd0, 0, 0, 3'd0, 0);

        // fetch beats a simultaneous request, which is dropped
        expect_o(3'd0, 1, 0, 0, 2'd0, 1, 0);
        step("fetch_req", 1, 1, 1, 3'd4, 0, 0, 0, 0, 0);
        idle("fetch_req_idle", 2'd0);

        // overflow beats a simultaneous fetch
        expect_o(3'd0, 0, 1, 0, 2'd2, 1, 0);
        step("ovf_save", 1, 1, 0, 3'd0, 0, 0, 1, 0, 0);
        exc_tail("ovf", 2'd2);

        expect_o(3'd0, 0, 1, 0, 2'd1, 1, 0);
        step("opc_div0_save", 1, 0, 0, 3'd0, 0, 0, 0, 1, 1);
        exc_tail("opc_div0", 2'd1);

        expect_o(3'd0, 0, 1, 0, 2'd3, 1, 0);
        step("div0_save", 1, 0, 0, 3'd0, 0, 0, 0, 0, 1);
        exc_tail("div0", 2'd3);

        // reserved kind: RESOLVE without done, then opcode exception
        expect_o(3'd0, 0, 0, 0, 2'd3, 1, 0);
        step("rsvd_resolve", 1, 0, 1, 3'd7, 0, 0, 0, 0, 0);
        expect_o(3'd0, 0, 1, 0, 2'd1, 1, 0);
        step("rsvd_save", 1, 0, 0, 3'd0, 0, 0, 0, 0, 0);
        exc_tail("rsvd", 2'd1);

        // reset during the second EXC_WAIT cycle
        expect_o(3'd0, 0, 1, 0, 2'd2, 1, 0);
        step("mid_save", 1, 0, 0, 3'd0, 0, 0, 1, 0, 0);
        expect_o(3'd0, 0, 0, 1, 2'd2, 1, 0);
        step("mid_wait1", 1, 0, 0, 3'd0, 0, 0, 0, 0, 0);
        expect_o(3'd0, 0, 0, 1, 2'd2, 1, 0);
        step("mid_wait2", 1, 0, 0, 3'd0, 0, 0, 0, 0, 0);
        expect_o(3'd0, 0, 0, 0, 2'd0, 0, 0);
        step("mid_reset", 0, 0, 0, 3'd0, 0, 0, 0, 0, 0);
        expect_o(3'd0, 1, 0, 0, 2'd0, 1, 0);
        step("post_fetch", 1, 1, 0, 3'd0, 0, 0, 0, 0, 0);
        idle("post_idle", 2'd0);

        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL sb_drain: observed %0d expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
